muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter WIDTH, default 32: operand/result width, any even value >= 8.
REQ-002 Parameter TAG_W, default 5: width of the destination tag carried with each operation.
REQ-003 clk  input  1  clock; all state changes on the rising edge.
REQ-004 rst  input  1  reset; asynchronous, active-low.
REQ-005 in_valid  input  1  operation offered.
REQ-006 in_ready  output  1  unit can accept an operation this cycle.
REQ-007 in_op  input  3  000 mul, 001 mulh, 010 mulhsu, 011 mulhu, 100 div, 101 divu, 110 rem, 111 remu.
REQ-008 in_op1, in_op2  input  WIDTH  operands (op1 = dividend/multiplicand).
REQ-009 in_tag  input  TAG_W  tag; returned unchanged with the result.
REQ-010 kill  input  1  abort any in-flight operation.
REQ-011 out_valid  output  1  result available.
REQ-012 out_ready  input  1  consumer takes the result.
REQ-013 out_res  output  WIDTH  result.
REQ-014 out_tag  output  TAG_W  tag of the result.

Function
REQ-015 Single operation in flight; states IDLE, MUL, DIV, DONE.
REQ-016 in_ready = 1 only in IDLE; accept occurs when in_valid & in_ready & !kill.
REQ-017 Multiply on accept: state -> MUL; next cycle, product registered, state -> DONE; out_valid asserted 2 cycles after the accept edge.
REQ-018 mul: low WIDTH bits of the product; mulh: high bits, signed x signed; mulhsu: signed op1 x unsigned op2; mulhu: unsigned x unsigned.
REQ-019 Divide with op2 == 0: quotient all ones, remainder = op1; state -> DONE directly; out_valid 1 cycle after accept.
REQ-020 Signed divide with op1 = most-negative and op2 = -1: quotient = op1, remainder = 0; state -> DONE directly.
REQ-021 Other divides: restoring algorithm on magnitudes, 1 quotient bit per cycle, WIDTH iterations counted by a clog2(WIDTH+1)-bit counter; state -> DONE after the last iteration; out_valid exactly WIDTH+1 cycles after accept.
REQ-022 Signed results: quotient negated if operand signs differ; remainder takes the sign of op1; fixup applied in the final iteration cycle.
REQ-023 DONE: out_valid=1; out_res/out_tag stable until out_ready; on out_valid & out_ready, state -> IDLE and in_ready is 1 the next cycle (no same-cycle re-accept).
REQ-024 kill in any state: state -> IDLE next edge; out_valid 0 next cycle; the result is discarded; kill takes priority over in_valid and out_ready in the same cycle.
REQ-025 out_res and out_tag hold their last value when out_valid=0; no X propagation from unaccepted inputs.

Reset
REQ-026 rst low: state IDLE, in_ready 1, out_valid 0, out_res 0, out_tag 0, counter 0, immediately and asynchronously.
REQ-027 Reset mid-division discards the operation; after release, the first accepted operation behaves as from power-up.

Structure
REQ-028 Package muldiv_pkg holds the op enum (3-bit), the state enum and the localparam function for the counter width.
REQ-029 One sub-module, muldiv_divider: the iterative restoring divider core with start/busy/done, instantiated once.
REQ-030 Multiplier uses a single (WIDTH+1)x(WIDTH+1) signed multiply on sign/zero-extended operands.

Verification (WIDTH=32)
REQ-031 mulh 0x80000000 x 0x80000000 -> out_res 0x40000000, out_valid 2 cycles after accept.
REQ-032 div -7 / 2 -> 0xFFFFFFFD; rem -7 % 2 -> 0xFFFFFFFF; each out_valid exactly 33 cycles after accept.
REQ-033 divu 5 / 0 -> 0xFFFFFFFF; remu 5 % 0 -> 5; div 0x80000000 / 0xFFFFFFFF -> 0x80000000; all latency 1.
REQ-034 kill at cycle 10 of a divide -> out_valid never rises, in_ready=1 next cycle; next mulhu 0xFFFFFFFF x 2 -> 1.
REQ-035 out_ready held 0 for 5 cycles in DONE -> out_res/out_tag stable, in_ready 0 throughout; release -> single handshake.
REQ-036 rst asserted mid-divide asynchronously -> out_valid 0 and in_ready 1 before the next clock edge.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared types and helpers for the multiply/divide unit.
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Width of a down-counter that must hold the value `width`.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

  function automatic logic op_is_mul(input op_e op);
    return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU};
  endfunction

  function automatic logic op_is_signed_div(input op_e op);
    return op inside {OP_DIV, OP_REM};
  endfunction

  function automatic logic op_is_rem(input op_e op);
    return op inside {OP_REM, OP_REMU};
  endfunction

endpackage

// File: rtl/muldiv_divider.sv
// Iterative restoring divider: one quotient bit per cycle on operand
// magnitudes, sign fixup folded into the final iteration's outputs.
// The divisor is assumed non-zero; the caller handles the zero and
// overflow corner cases without starting the core.
module muldiv_divider
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int CNT_W = cnt_width(WIDTH);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             q_neg_q, q_neg_d;
  logic             r_neg_q, r_neg_d;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic             q_bit;
  logic [WIDTH-1:0] quo_next;
  logic [WIDTH-1:0] rem_next;
  logic             a_neg;
  logic             b_neg;

  assign busy = (cnt_q != '0);
  assign done = (cnt_q == CNT_W'(1));

  // One restoring step plus the signed view of the result it would produce.
  always_comb begin
    shifted   = {rem_q, quo_q[WIDTH-1]};
    trial     = shifted - {1'b0, dvs_q};
    q_bit     = ~trial[WIDTH];
    rem_next  = q_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
    quo_next  = {quo_q[WIDTH-2:0], q_bit};
    quotient  = q_neg_q ? -quo_next : quo_next;
    remainder = r_neg_q ? -rem_next : rem_next;
  end

  // Load magnitudes on start, iterate while the down-counter is non-zero.
  always_comb begin
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dvs_d   = dvs_q;
    q_neg_d = q_neg_q;
    r_neg_d = r_neg_q;
    a_neg   = signed_op & dividend[WIDTH-1];
    b_neg   = signed_op & divisor[WIDTH-1];
    if (abort) begin
      cnt_d = '0;
    end else if (start) begin
      cnt_d   = CNT_W'(WIDTH);
      quo_d   = a_neg ? -dividend : dividend;
      dvs_d   = b_neg ? -divisor : divisor;
      rem_d   = '0;
      q_neg_d = a_neg ^ b_neg;
      r_neg_d = a_neg;
    end else if (busy) begin
      cnt_d = cnt_q - CNT_W'(1);
      quo_d = quo_next;
      rem_d = rem_next;
    end
  end

  // Divider state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dvs_q   <= '0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dvs_q   <= dvs_d;
      q_neg_q <= q_neg_d;
      r_neg_q <= r_neg_d;
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Single-issue multiply/divide unit with tag passthrough.
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | ready for a new operation
// MUL     | operands latched, product registered on the next edge
// DIV     | restoring divider iterating
// DONE    | result held on out_res/out_tag until out_ready
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [WIDTH-1:0] in_op1,
  input  logic [WIDTH-1:0] in_op2,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             kill,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_res,
  output logic [TAG_W-1:0] out_tag
);

  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [WIDTH-1:0] op1_q, op1_d;
  logic [WIDTH-1:0] op2_q, op2_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [WIDTH-1:0] out_res_q, out_res_d;
  logic [TAG_W-1:0] out_tag_q, out_tag_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;

  op_e                     in_op_e;
  logic                    accept;
  logic                    div_zero;
  logic                    div_ovf;
  logic                    div_start;
  logic                    div_busy_unused;
  logic                    div_done;
  logic [WIDTH-1:0]        div_quo;
  logic [WIDTH-1:0]        div_rem;

  logic signed [WIDTH:0]     mul_a;
  logic signed [WIDTH:0]     mul_b;
  logic signed [2*WIDTH+1:0] mul_p;
  logic                      unused_mul_top;

  assign in_op_e   = op_e'(in_op);
  assign accept    = in_valid & in_ready_q & ~kill;
  assign div_zero  = (in_op2 == '0);
  assign div_ovf   = op_is_signed_div(in_op_e) & (in_op1 == MOST_NEG) & (in_op2 == '1);

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_res   = out_res_q;
  assign out_tag   = out_tag_q;

  // One (WIDTH+1)-square signed multiply; the extension bit selects signedness.
  always_comb begin
    mul_a = {((op_q == OP_MULH) | (op_q == OP_MULHSU)) & op1_q[WIDTH-1], op1_q};
    mul_b = {(op_q == OP_MULH) & op2_q[WIDTH-1], op2_q};
    mul_p = mul_a * mul_b;
    unused_mul_top = ^mul_p[2*WIDTH+1:2*WIDTH];
  end

  muldiv_divider #(
    .WIDTH(WIDTH)
  ) u_divider (
    .clk       (clk),
    .rst       (rst),
    .start     (div_start),
    .abort     (kill),
    .signed_op (op_is_signed_div(in_op_e)),
    .dividend  (in_op1),
    .divisor   (in_op2),
    .busy      (div_busy_unused),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  // Next-state and result selection; kill overrides every other request.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    op1_d     = op1_q;
    op2_d     = op2_q;
    tag_d     = tag_q;
    out_res_d = out_res_q;
    out_tag_d = out_tag_q;
    div_start = 1'b0;
    if (kill) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            op_d  = in_op_e;
            op1_d = in_op1;
            op2_d = in_op2;
            tag_d = in_tag;
            if (op_is_mul(in_op_e)) begin
              state_d = ST_MUL;
            end else if (div_zero) begin
              out_res_d = op_is_rem(in_op_e) ? in_op1 : '1;
              out_tag_d = in_tag;
              state_d   = ST_DONE;
            end else if (div_ovf) begin
              out_res_d = op_is_rem(in_op_e) ? '0 : in_op1;
              out_tag_d = in_tag;
              state_d   = ST_DONE;
            end else begin
              div_start = 1'b1;
              state_d   = ST_DIV;
            end
          end
        end
        ST_MUL: begin
          out_res_d = (op_q == OP_MUL) ? mul_p[WIDTH-1:0] : mul_p[2*WIDTH-1:WIDTH];
          out_tag_d = tag_q;
          state_d   = ST_DONE;
        end
        ST_DIV: begin
          if (div_done) begin
            out_res_d = op_is_rem(op_q) ? div_rem : div_quo;
            out_tag_d = tag_q;
            state_d   = ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
    in_ready_d  = (state_d == ST_IDLE);
    out_valid_d = (state_d == ST_DONE);
  end

  // FSM state, latched operands and registered handshake outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_MUL;
      op1_q       <= '0;
      op2_q       <= '0;
      tag_q       <= '0;
      out_res_q   <= '0;
      out_tag_q   <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      op1_q       <= op1_d;
      op2_q       <= op2_d;
      tag_q       <= tag_d;
      out_res_q   <= out_res_d;
      out_tag_q   <= out_tag_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed and randomized checks of muldiv_unit against an arithmetic model.
module tb_muldiv_unit;

  localparam int W = 32;
  localparam logic [31:0] MIN = 32'h8000_0000;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_op;
  logic [31:0] in_op1;
  logic [31:0] in_op2;
  logic [4:0]  in_tag;
  logic        kill;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_res;
  logic [4:0]  out_tag;

  int checks   = 0;
  int failures = 0;
  int seen;
  logic [2:0]  r_op;
  logic [31:0] r_a;
  logic [31:0] r_b;

  muldiv_unit #(.WIDTH(W), .TAG_W(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_op1    (in_op1),
    .in_op2    (in_op2),
    .in_tag    (in_tag),
    .kill      (kill),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_res   (out_res),
    .out_tag   (out_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference result from plain integer arithmetic.
  function automatic logic [31:0] ref_res(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint   sa;
    longint   sb;
    longint   ub;
    longint   p;
    bit [63:0] pu;
    sa = $signed(a);
    sb = $signed(b);
    ub = {32'h0, b};
    case (op)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin pu = {32'h0, a} * {32'h0, b}; return pu[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == MIN && b == 32'hFFFF_FFFF) return a;
        p = sa / sb; return p[31:0];
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == MIN && b == 32'hFFFF_FFFF) return 32'h0;
        p = sa % sb; return p[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op < 3'd4) return 2;
    if (b == 0) return 1;
    if ((op == 3'd4 || op == 3'd6) && a == MIN && b == 32'hFFFF_FFFF) return 1;
    return W + 1;
  endfunction

  task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] tag,
                        input logic [31:0] exp_res, input int exp_lat, input int hold);
    int lat;
    @(negedge clk);
    check({name, ".rdy"}, in_ready, 1);
    in_valid = 1'b1; in_op = op; in_op1 = a; in_op2 = b; in_tag = tag;
    @(posedge clk); #1;
    in_valid = 1'b0; in_op = 3'($urandom); in_op1 = $urandom; in_op2 = $urandom; in_tag = 5'($urandom);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) check({name, ".busy_rdy"}, in_ready, 0);
    end while (out_valid !== 1'b1 && lat < 100);
    check({name, ".lat"}, lat, exp_lat);
    check({name, ".res"}, out_res, exp_res);
    check({name, ".tag"}, out_tag, tag);
    repeat (hold) begin
      @(negedge clk);
      check({name, ".hold_vld"}, out_valid, 1);
      check({name, ".hold_res"}, out_res, exp_res);
      check({name, ".hold_tag"}, out_tag, tag);
      check({name, ".hold_rdy"}, in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({name, ".post_vld"}, out_valid, 0);
    check({name, ".post_rdy"}, in_ready, 1);
    check({name, ".post_res"}, out_res, exp_res);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_op = '0; in_op1 = '0; in_op2 = '0; in_tag = '0;
    kill = 1'b0; out_ready = 1'b0;
    #1 rst = 1'b0;
    #2;
    check("reset.rdy", in_ready, 1);
    check("reset.vld", out_valid, 0);
    check("reset.res", out_res, 0);
    check("reset.tag", out_tag, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    run_op("mulh_min", 3'd1, MIN, MIN, 5'd1, 32'h4000_0000, 2, 0);
    run_op("div_m7_2", 3'd4, 32'hFFFF_FFF9, 32'd2, 5'd2, 32'hFFFF_FFFD, 33, 0);
    run_op("rem_m7_2", 3'd6, 32'hFFFF_FFF9, 32'd2, 5'd3, 32'hFFFF_FFFF, 33, 0);
    run_op("divu_0", 3'd5, 32'd5, 32'd0, 5'd4, 32'hFFFF_FFFF, 1, 0);
    run_op("remu_0", 3'd7, 32'd5, 32'd0, 5'd5, 32'd5, 1, 0);
    run_op("div_ovf", 3'd4, MIN, 32'hFFFF_FFFF, 5'd6, MIN, 1, 0);
    run_op("mul_lo", 3'd0, 32'h1234_5678, 32'h9ABC_DEF0, 5'd7, 32'h242D_2080, 2, 0);
    run_op("hold5", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8, 32'hFFFF_FFFF, 2, 5);

    // kill beats in_valid while idle
    @(negedge clk);
    in_valid = 1'b1; kill = 1'b1; in_op = 3'd5; in_op1 = 32'd5; in_op2 = 32'd0; in_tag = 5'd10;
    @(posedge clk); #1;
    in_valid = 1'b0; kill = 1'b0;
    check("killprio.vld", out_valid, 0);
    check("killprio.rdy", in_ready, 1);

    // kill at cycle 10 of a divide
    @(negedge clk);
    in_valid = 1'b1; in_op = 3'd4; in_op1 = 32'd100; in_op2 = 32'd7; in_tag = 5'd11;
    @(posedge clk); #1;
    in_valid = 1'b0;
    seen = 0;
    repeat (9) begin
      @(negedge clk);
      if (out_valid !== 1'b0) seen = 1;
    end
    @(negedge clk);
    kill = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0;
    check("kill.vld", out_valid, 0);
    check("kill.rdy", in_ready, 1);
    repeat (40) begin
      @(negedge clk);
      if (out_valid !== 1'b0) seen = 1;
    end
    check("kill.never_valid", seen, 0);
    run_op("mulhu_after_kill", 3'd3, 32'hFFFF_FFFF, 32'd2, 5'd12, 32'd1, 2, 0);

    // asynchronous reset in the middle of a divide
    @(negedge clk);
    in_valid = 1'b1; in_op = 3'd5; in_op1 = 32'd1000; in_op2 = 32'd3; in_tag = 5'd13;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("arst.vld", out_valid, 0);
    check("arst.rdy", in_ready, 1);
    check("arst.res", out_res, 0);
    check("arst.tag", out_tag, 0);
    @(negedge clk);
    rst = 1'b1;
    run_op("div_after_rst", 3'd4, 32'hFFFF_FFF9, 32'd2, 5'd14, 32'hFFFF_FFFD, 33, 0);

    for (int i = 0; i < 40; i++) begin
      r_op = 3'($urandom);
      r_a  = $urandom;
      r_b  = $urandom;
      case ($urandom_range(0, 4))
        0: r_b = 32'd0;
        1: begin r_a = MIN; r_b = 32'hFFFF_FFFF; end
        2: r_b = $urandom_range(1, 15);
        default: ;
      endcase
      run_op($sformatf("rnd%0d", i), r_op, r_a, r_b, 5'($urandom),
             ref_res(r_op, r_a, r_b), ref_lat(r_op, r_a, r_b), $urandom_range(0, 2));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
